// File: rtl/exmem_skid_stage.sv
// EX/MEM pipeline register with valid/ready handshake, 2-entry skid buffer and flush.
// Optional: define EXMEM_FWD_EN to add the fwd_valid/fwd_addr/fwd_data forwarding taps.
module exmem_skid_stage #(
  parameter int WB_W     = 2,
  parameter int MEM_W    = 2,
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int REGW_BIT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WB_W-1:0]   wb_in,
  input  logic [MEM_W-1:0]  mem_in,
  input  logic [DATA_W-1:0] alu_in,
  input  logic [DATA_W-1:0] wdata_in,
  input  logic [ADDR_W-1:0] dest_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WB_W-1:0]   wb_out,
  output logic [MEM_W-1:0]  mem_out,
  output logic [DATA_W-1:0] alu_out,
  output logic [DATA_W-1:0] wdata_out,
  output logic [ADDR_W-1:0] dest_out,
`ifdef EXMEM_FWD_EN
  output logic              fwd_valid,
  output logic [ADDR_W-1:0] fwd_addr,
  output logic [DATA_W-1:0] fwd_data,
`endif
  output logic [1:0]        occupancy
);

  typedef struct packed {
    logic [WB_W-1:0]   wb;
    logic [MEM_W-1:0]  mem;
    logic [DATA_W-1:0] alu;
    logic [DATA_W-1:0] wdata;
    logic [ADDR_W-1:0] dest;
  } beat_t;

  beat_t main_q, main_d;
  beat_t skid_q, skid_d;
  logic  main_valid_q, main_valid_d;
  logic  skid_valid_q, skid_valid_d;

  beat_t in_beat;
  logic  accept;
  logic  pop;

  assign in_beat = '{wb: wb_in, mem: mem_in, alu: alu_in, wdata: wdata_in, dest: dest_in};

  // in_ready comes straight from a flop, so upstream never sees a path from out_ready.
  assign in_ready = !skid_valid_q;
  assign accept   = in_valid && in_ready;
  assign pop      = main_valid_q && out_ready;

  always_comb begin
    main_d       = main_q;
    skid_d       = skid_q;
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    if (flush) begin
      // Data is left in place; only the valid bits drop, turning the outputs into a bubble.
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (!main_valid_q || pop) begin
      if (skid_valid_q) begin
        main_d       = skid_q;
        main_valid_d = 1'b1;
        if (accept) begin
          skid_d       = in_beat;
          skid_valid_d = 1'b1;
        end else begin
          skid_valid_d = 1'b0;
        end
      end else if (accept) begin
        main_d       = in_beat;
        main_valid_d = 1'b1;
      end else begin
        main_valid_d = 1'b0;
      end
    end else if (accept) begin
      skid_d       = in_beat;
      skid_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      main_q       <= '0;
      skid_q       <= '0;
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
    end else begin
      main_q       <= main_d;
      skid_q       <= skid_d;
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
    end
  end

  assign out_valid = main_valid_q;
  assign wb_out    = main_valid_q ? main_q.wb  : '0;
  assign mem_out   = main_valid_q ? main_q.mem : '0;
  assign alu_out   = main_q.alu;
  assign wdata_out = main_q.wdata;
  assign dest_out  = main_q.dest;
  assign occupancy = {1'b0, main_valid_q} + {1'b0, skid_valid_q};

`ifdef EXMEM_FWD_EN
  assign fwd_valid = out_valid & wb_out[REGW_BIT] & (dest_out != '0);
  assign fwd_addr  = dest_out;
  assign fwd_data  = alu_out;
`endif

endmodule
